// File: rtl/hpdcache_arb_pkg.sv
// Shared types for the HPDcache request arbiter: the configuration-derived widths,
// the buffered request record, the quiesce FSM states and the tag packing helpers.
package hpdcache_arb_pkg;

   typedef struct packed {
      int NrDcacheReq;
      int DcacheAddrWidth;
      int DcacheDataWidth;
      int DcacheIdWidth;
      int DcacheMaxOutstanding;
   } cva6_cfg_t;

   localparam cva6_cfg_t CVA6_CFG = '{
      NrDcacheReq:          3,
      DcacheAddrWidth:      64,
      DcacheDataWidth:      64,
      DcacheIdWidth:        3,
      DcacheMaxOutstanding: 4
   };

   localparam int NrReq          = CVA6_CFG.NrDcacheReq;
   localparam int AddrWidth      = CVA6_CFG.DcacheAddrWidth;
   localparam int DataWidth      = CVA6_CFG.DcacheDataWidth;
   localparam int BeWidth        = DataWidth / 8;
   localparam int TidWidth       = CVA6_CFG.DcacheIdWidth;
   localparam int MaxOutstanding = CVA6_CFG.DcacheMaxOutstanding;
   localparam int IdxW           = $clog2(NrReq);
   localparam int TagW           = IdxW + TidWidth;
   localparam int CntW           = $clog2(MaxOutstanding + 1);

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic                 we;
      logic [DataWidth-1:0] wdata;
      logic [BeWidth-1:0]   be;
      logic [TagW-1:0]      tid;
   } hpdcache_req_t;

   typedef enum logic [1:0] {
      ARB_RUN,
      ARB_DRAIN,
      ARB_IDLE
   } arb_state_e;

   function automatic logic [TagW-1:0] pack_tag(input logic [IdxW-1:0]     idx,
                                                input logic [TidWidth-1:0] tid);
      return {idx, tid};
   endfunction

   function automatic logic [IdxW-1:0] tag_idx(input logic [TagW-1:0] tag);
      return tag[TagW-1 -: IdxW];
   endfunction

   function automatic logic [TidWidth-1:0] tag_tid(input logic [TagW-1:0] tag);
      return tag[TidWidth-1:0];
   endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin pick among N request lines; the pointer moves to one past the winner
// whenever a grant is issued.
module rr_arbiter_core #(
   parameter int N = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [N-1:0]  i_req,
   output logic [N-1:0]  o_gnt,
   output logic          o_gnt_valid,
   output logic [IW-1:0] o_gnt_idx
);

   logic [IW-1:0] r_ptr;
   logic          w_found;
   logic [IW-1:0] w_idx;

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N) s = s - N;
      return s[IW-1:0];
   endfunction

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      for (int off = 0; off < N; off++) begin
         if (!w_found && i_req[wrap_add(r_ptr, off)]) begin
            w_found = 1'b1;
            w_idx   = wrap_add(r_ptr, off);
         end
      end
   end

   assign o_gnt       = w_found ? (N'(1) << w_idx) : '0;
   assign o_gnt_valid = w_found;
   assign o_gnt_idx   = w_idx;

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr <= '0;
      end else if (w_found) begin
         r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + IW'(1);
      end
   end

endmodule

// File: rtl/hpdcache_req_arbiter.sv
// Shares one data-cache request port among NrReq requesters with a one-entry output
// stage, tagged response routing, per-requester in-flight counters and a quiesce handshake.
module hpdcache_req_arbiter
   import hpdcache_arb_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NrReq-1:0]          req_valid_i,
   output logic [NrReq-1:0]          req_ready_o,
   input  logic [NrReq*AddrWidth-1:0] req_addr_i,
   input  logic [NrReq-1:0]          req_we_i,
   input  logic [NrReq*DataWidth-1:0] req_wdata_i,
   input  logic [NrReq*BeWidth-1:0]  req_be_i,
   input  logic [NrReq*TidWidth-1:0] req_tid_i,
   output logic                      mem_req_valid_o,
   input  logic                      mem_req_ready_i,
   output logic [AddrWidth-1:0]      mem_req_addr_o,
   output logic                      mem_req_we_o,
   output logic [DataWidth-1:0]      mem_req_wdata_o,
   output logic [BeWidth-1:0]        mem_req_be_o,
   output logic [TagW-1:0]           mem_req_tid_o,
   input  logic                      mem_rsp_valid_i,
   input  logic [TagW-1:0]           mem_rsp_tid_i,
   input  logic [DataWidth-1:0]      mem_rsp_rdata_i,
   output logic [NrReq-1:0]          rsp_valid_o,
   output logic [TidWidth-1:0]       rsp_tid_o,
   output logic [DataWidth-1:0]      rsp_rdata_o,
   input  logic                      flush_i,
   output logic                      flush_idle_o,
   output logic                      err_o
);

   hpdcache_req_t   r_buf;
   hpdcache_req_t   w_win;
   logic            r_valid;
   logic [CntW-1:0] r_cnt     [NrReq];
   logic [CntW-1:0] w_cnt_nxt [NrReq];
   arb_state_e      r_state;
   arb_state_e      w_state_nxt;
   logic            r_err;
   logic            w_accept;
   logic [NrReq-1:0] w_elig;
   logic [NrReq-1:0] w_gnt;
   logic            w_gnt_valid;
   logic [IdxW-1:0] w_gnt_idx;
   logic [IdxW-1:0] w_rsp_idx;
   logic            w_rsp_err;
   logic            w_empty_nxt;

   assign w_accept = !r_valid || mem_req_ready_i;

   // A flush request blocks grants in the very cycle it is raised.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NrReq; i++) begin
         w_elig[i] = req_valid_i[i] && (r_cnt[i] < CntW'(MaxOutstanding)) &&
                     (r_state == ARB_RUN) && !flush_i && w_accept;
      end
   end

   rr_arbiter_core #(.N(NrReq)) u_rr (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_req       (w_elig),
      .o_gnt       (w_gnt),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_idx   (w_gnt_idx)
   );

   assign req_ready_o = w_gnt;

   always_comb begin
      w_win.addr  = req_addr_i[w_gnt_idx*AddrWidth +: AddrWidth];
      w_win.we    = req_we_i[w_gnt_idx];
      w_win.wdata = req_wdata_i[w_gnt_idx*DataWidth +: DataWidth];
      w_win.be    = req_be_i[w_gnt_idx*BeWidth +: BeWidth];
      w_win.tid   = pack_tag(w_gnt_idx, req_tid_i[w_gnt_idx*TidWidth +: TidWidth]);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid <= 1'b0;
         r_buf   <= '0;
      end else if (w_gnt_valid) begin
         r_valid <= 1'b1;
         r_buf   <= w_win;
      end else if (mem_req_ready_i) begin
         r_valid <= 1'b0;
      end
   end

   assign mem_req_valid_o = r_valid;
   assign mem_req_addr_o  = r_buf.addr;
   assign mem_req_we_o    = r_buf.we;
   assign mem_req_wdata_o = r_buf.wdata;
   assign mem_req_be_o    = r_buf.be;
   assign mem_req_tid_o   = r_buf.tid;

   assign w_rsp_idx   = tag_idx(mem_rsp_tid_i);
   assign rsp_tid_o   = tag_tid(mem_rsp_tid_i);
   assign rsp_rdata_o = mem_rsp_rdata_i;

   always_comb begin
      rsp_valid_o = '0;
      for (int i = 0; i < NrReq; i++) begin
         rsp_valid_o[i] = mem_rsp_valid_i && (w_rsp_idx == IdxW'(i));
      end
   end

   // Out-of-range tags and responses to an idle requester are errors; counters never underflow.
   always_comb begin
      w_rsp_err   = mem_rsp_valid_i && (int'(w_rsp_idx) >= NrReq);
      w_empty_nxt = !(w_gnt_valid || (r_valid && !mem_req_ready_i));
      for (int i = 0; i < NrReq; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         if (rsp_valid_o[i] && (r_cnt[i] == '0)) w_rsp_err = 1'b1;
         if (w_gnt[i] && !(rsp_valid_o[i] && (r_cnt[i] != '0))) begin
            w_cnt_nxt[i] = r_cnt[i] + CntW'(1);
         end else if (!w_gnt[i] && rsp_valid_o[i] && (r_cnt[i] != '0)) begin
            w_cnt_nxt[i] = r_cnt[i] - CntW'(1);
         end
         if (w_cnt_nxt[i] != '0) w_empty_nxt = 1'b0;
      end
   end

   // Emptiness is judged on next-cycle values so a quiet system reaches IDLE one cycle after flush_i.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ARB_RUN:   if (flush_i) w_state_nxt = w_empty_nxt ? ARB_IDLE : ARB_DRAIN;
         ARB_DRAIN: begin
            if (!flush_i)         w_state_nxt = ARB_RUN;
            else if (w_empty_nxt) w_state_nxt = ARB_IDLE;
         end
         ARB_IDLE:  if (!flush_i) w_state_nxt = ARB_RUN;
         default:   w_state_nxt = ARB_RUN;
      endcase
   end

   // NOTE: r_cnt is a small flop array, not a RAM, so it is cleared by reset like any other state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ARB_RUN;
         r_err   <= 1'b0;
         for (int i = 0; i < NrReq; i++) r_cnt[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= r_err || w_rsp_err;
         for (int i = 0; i < NrReq; i++) r_cnt[i] <= w_cnt_nxt[i];
      end
   end

   assign flush_idle_o = (r_state == ARB_IDLE);
   assign err_o        = r_err;

endmodule

// File: tb/tb_hpdcache_req_arbiter.sv
// Self-checking bench: randomized and directed stimulus compared every cycle against
// a cycle-level behavioural model of the arbiter built from plain integers.
module tb_hpdcache_req_arbiter;
   import hpdcache_arb_pkg::*;

   localparam int M_RUN   = 0;
   localparam int M_DRAIN = 1;
   localparam int M_IDLE  = 2;

   logic                       clk_i = 1'b0;
   logic                       rst_i;
   logic [NrReq-1:0]           req_valid_i;
   logic [NrReq-1:0]           req_ready_o;
   logic [NrReq*AddrWidth-1:0] req_addr_i;
   logic [NrReq-1:0]           req_we_i;
   logic [NrReq*DataWidth-1:0] req_wdata_i;
   logic [NrReq*BeWidth-1:0]   req_be_i;
   logic [NrReq*TidWidth-1:0]  req_tid_i;
   logic                       mem_req_valid_o;
   logic                       mem_req_ready_i;
   logic [AddrWidth-1:0]       mem_req_addr_o;
   logic                       mem_req_we_o;
   logic [DataWidth-1:0]       mem_req_wdata_o;
   logic [BeWidth-1:0]         mem_req_be_o;
   logic [TagW-1:0]            mem_req_tid_o;
   logic                       mem_rsp_valid_i;
   logic [TagW-1:0]            mem_rsp_tid_i;
   logic [DataWidth-1:0]       mem_rsp_rdata_i;
   logic [NrReq-1:0]           rsp_valid_o;
   logic [TidWidth-1:0]        rsp_tid_o;
   logic [DataWidth-1:0]       rsp_rdata_o;
   logic                       flush_i;
   logic                       flush_idle_o;
   logic                       err_o;

   hpdcache_req_arbiter dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_addr_i      (req_addr_i),
      .req_we_i        (req_we_i),
      .req_wdata_i     (req_wdata_i),
      .req_be_i        (req_be_i),
      .req_tid_i       (req_tid_i),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_req_we_o    (mem_req_we_o),
      .mem_req_wdata_o (mem_req_wdata_o),
      .mem_req_be_o    (mem_req_be_o),
      .mem_req_tid_o   (mem_req_tid_o),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rsp_tid_i   (mem_rsp_tid_i),
      .mem_rsp_rdata_i (mem_rsp_rdata_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_tid_o       (rsp_tid_o),
      .rsp_rdata_o     (rsp_rdata_o),
      .flush_i         (flush_i),
      .flush_idle_o    (flush_idle_o),
      .err_o           (err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state.
   int                   m_cnt [NrReq];
   int                   m_rr;
   bit                   m_bv;
   logic [AddrWidth-1:0] m_addr;
   logic                 m_we;
   logic [DataWidth-1:0] m_wdata;
   logic [BeWidth-1:0]   m_be;
   logic [TagW-1:0]      m_tag;
   int                   m_mode;
   bit                   m_err;
   int                   last_gnt;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NrReq; i++) m_cnt[i] = 0;
      m_rr = 0; m_bv = 0; m_addr = '0; m_we = 0; m_wdata = '0; m_be = '0; m_tag = '0;
      m_mode = M_RUN; m_err = 0; last_gnt = -1;
   endtask

   task automatic clear_inputs();
      req_valid_i = '0; req_addr_i = '0; req_we_i = '0; req_wdata_i = '0; req_be_i = '0;
      req_tid_i = '0; mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_tid_i = '0;
      mem_rsp_rdata_i = '0; flush_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      model_reset();
   endtask

   // Compare all outputs for the current inputs, then advance the model across one clock edge.
   task automatic tick();
      int g, j, idx;
      bit acc, empty;
      logic [NrReq-1:0] exp_ready, exp_rsp;
      #1;
      acc = !m_bv || mem_req_ready_i;
      g = -1;
      if (acc && m_mode == M_RUN && !flush_i) begin
         for (int k = 0; k < NrReq; k++) begin
            j = (m_rr + k) % NrReq;
            if (g < 0 && req_valid_i[j] && m_cnt[j] < MaxOutstanding) g = j;
         end
      end
      exp_ready = (g >= 0) ? (NrReq'(1) << g) : '0;
      idx = int'(mem_rsp_tid_i) >> TidWidth;
      exp_rsp = (mem_rsp_valid_i && idx < NrReq) ? (NrReq'(1) << idx) : '0;

      check("req_ready",  req_ready_o,     exp_ready);
      check("mem_valid",  mem_req_valid_o, m_bv);
      check("mem_addr",   mem_req_addr_o,  m_addr);
      check("mem_we",     mem_req_we_o,    m_we);
      check("mem_wdata",  mem_req_wdata_o, m_wdata);
      check("mem_be",     mem_req_be_o,    m_be);
      check("mem_tid",    mem_req_tid_o,   m_tag);
      check("rsp_valid",  rsp_valid_o,     exp_rsp);
      check("rsp_tid",    rsp_tid_o,       mem_rsp_tid_i % (1 << TidWidth));
      check("rsp_rdata",  rsp_rdata_o,     mem_rsp_rdata_i);
      check("flush_idle", flush_idle_o,    m_mode == M_IDLE);
      check("err",        err_o,           m_err);

      if (mem_rsp_valid_i) begin
         if (idx >= NrReq || m_cnt[idx] == 0) m_err = 1;
         else m_cnt[idx]--;
      end
      if (g >= 0) begin
         m_cnt[g]++;
         m_bv    = 1;
         m_addr  = req_addr_i[g*AddrWidth +: AddrWidth];
         m_we    = req_we_i[g];
         m_wdata = req_wdata_i[g*DataWidth +: DataWidth];
         m_be    = req_be_i[g*BeWidth +: BeWidth];
         m_tag   = TagW'(g * (1 << TidWidth) + int'(req_tid_i[g*TidWidth +: TidWidth]));
         m_rr    = (g + 1) % NrReq;
      end else if (mem_req_ready_i) begin
         m_bv = 0;
      end
      last_gnt = g;
      empty = !m_bv;
      for (int i = 0; i < NrReq; i++) if (m_cnt[i] != 0) empty = 0;
      case (m_mode)
         M_RUN:   if (flush_i) m_mode = empty ? M_IDLE : M_DRAIN;
         M_DRAIN: if (!flush_i) m_mode = M_RUN; else if (empty) m_mode = M_IDLE;
         default: if (!flush_i) m_mode = M_RUN;
      endcase
      @(posedge clk_i);
      #1;
   endtask

   task automatic rand_fields();
      for (int i = 0; i < NrReq; i++) begin
         req_addr_i[i*AddrWidth +: AddrWidth]  = {$urandom, $urandom};
         req_wdata_i[i*DataWidth +: DataWidth] = {$urandom, $urandom};
         req_be_i[i*BeWidth +: BeWidth]        = BeWidth'($urandom);
         req_tid_i[i*TidWidth +: TidWidth]     = TidWidth'($urandom);
         req_we_i[i]                           = $urandom_range(0, 1) == 1;
      end
      mem_rsp_rdata_i = {$urandom, $urandom};
   endtask

   task automatic respond(input int idx);
      mem_rsp_valid_i = 1'b1;
      mem_rsp_tid_i   = TagW'(idx * (1 << TidWidth) + int'($urandom_range(0, (1 << TidWidth) - 1)));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int cand [$];
      do_reset();
      check("rst_mem_valid",  mem_req_valid_o, 1'b0);
      check("rst_mem_addr",   mem_req_addr_o,  '0);
      check("rst_flush_idle", flush_idle_o,    1'b0);
      check("rst_err",        err_o,           1'b0);
      tick();

      // Randomized traffic, responses only for requesters with work in flight.
      for (int n = 0; n < 1500; n++) begin
         rand_fields();
         req_valid_i     = NrReq'($urandom);
         mem_req_ready_i = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 39) == 0) flush_i = !flush_i;
         mem_rsp_valid_i = 1'b0;
         cand.delete();
         for (int i = 0; i < NrReq; i++) if (m_cnt[i] > 0) cand.push_back(i);
         if (cand.size() > 0 && $urandom_range(0, 2) != 0)
            respond(cand[$urandom_range(0, cand.size() - 1)]);
         tick();
      end

      // Requester 1: three back-to-back loads, then three responses.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         req_valid_i = 3'b010;
         req_tid_i[TidWidth +: TidWidth] = TidWidth'(k + 5);
         tick();
      end
      req_valid_i = '0;
      check("A_tid", mem_req_tid_o, {2'd1, 3'd7});
      for (int k = 0; k < 3; k++) begin respond(1); tick(); end
      mem_rsp_valid_i = 1'b0;
      tick();

      // All requesters valid: strict rotation.
      do_reset();
      req_valid_i = 3'b111;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("B_order", last_gnt, k % NrReq);
      end

      // Stalled store must hold.
      do_reset();
      req_valid_i = 3'b100; req_we_i = 3'b100;
      req_addr_i[2*AddrWidth +: AddrWidth] = 64'h8000_0000;
      tick();
      req_valid_i = 3'b111; mem_req_ready_i = 1'b0;
      rand_fields();
      for (int k = 0; k < 4; k++) begin
         tick();
         check("C_addr", mem_req_addr_o, 64'h8000_0000);
      end
      mem_req_ready_i = 1'b1;
      tick();

      // Requester 0 saturates; others still served; one response re-enables it.
      do_reset();
      req_valid_i = 3'b001;
      repeat (6) tick();
      req_valid_i = 3'b111;
      repeat (3) tick();
      req_valid_i = 3'b001;
      respond(0); tick();
      mem_rsp_valid_i = 1'b0;
      tick();
      check("D_regrant", last_gnt, 0);

      // Quiesce with two requests outstanding.
      do_reset();
      req_valid_i = 3'b001;
      repeat (2) tick();
      flush_i = 1'b1; req_valid_i = 3'b111;
      repeat (2) tick();
      respond(0); tick();
      mem_rsp_valid_i = 1'b0;
      repeat (2) tick();
      respond(0); tick();
      mem_rsp_valid_i = 1'b0;
      check("E_idle_rise", flush_idle_o, 1'b1);
      tick();
      flush_i = 1'b0;
      repeat (3) tick();
      check("E_resumed", flush_idle_o, 1'b0);

      // Error cases: response to an idle requester, out-of-range index.
      do_reset();
      respond(0); tick();
      mem_rsp_valid_i = 1'b0;
      check("F_err_set", err_o, 1'b1);
      respond(3); tick();
      mem_rsp_valid_i = 1'b0;
      repeat (3) tick();
      check("F_err_sticky", err_o, 1'b1);
      do_reset();
      check("F_err_cleared", err_o, 1'b0);

      // Reset mid-transaction then a late response.
      req_valid_i = 3'b010;
      tick();
      do_reset();
      check("G_valid_dropped", mem_req_valid_o, 1'b0);
      respond(1); tick();
      mem_rsp_valid_i = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hpdcache_req_arbiter.md
Name: hpdcache_req_arbiter

Overview:
- Shares one data-cache request port among NrReq requesters (load unit, store unit, PTW, CVXIF/accelerator).
- Uses round-robin arbitration and a one-entry registered output stage.
- Tags each granted request with the requester index so that responses can be routed back.
- Tracks outstanding transactions per requester, and provides a drain/quiesce handshake used before fence.i, cache flush and mode switches.

Parameters:
- NrReq, 3, number of requesters (>=2).
- AddrWidth, 64, request address width.
- DataWidth, 64, read/write data width.
- TidWidth, 3, requester-side transaction ID width.
- MaxOutstanding, 4, maximum in-flight requests per requester.
- IdxW, $clog2(NrReq), derived; requester index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NrReq  per-requester request valid
- req_ready_o  out  NrReq  per-requester grant (transfer when valid&ready)
- req_addr_i  in  NrReq*AddrWidth  request address
- req_we_i  in  NrReq  1=store, 0=load
- req_wdata_i  in  NrReq*DataWidth  store data
- req_be_i  in  NrReq*(DataWidth/8)  byte enables
- req_tid_i  in  NrReq*TidWidth  requester transaction ID
- mem_req_valid_o  out  1  cache request valid
- mem_req_ready_i  in  1  cache accepts request
- mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_be_o  out  AddrWidth/1/DataWidth/DataWidth/8  forwarded request fields
- mem_req_tid_o  out  IdxW+TidWidth  {requester index, requester tid}
- mem_rsp_valid_i  in  1  cache response valid (no backpressure)
- mem_rsp_tid_i  in  IdxW+TidWidth  response tag
- mem_rsp_rdata_i  in  DataWidth  response data
- rsp_valid_o  out  NrReq  one-hot routed response valid
- rsp_tid_o  out  TidWidth  low TidWidth bits of mem_rsp_tid_i
- rsp_rdata_o  out  DataWidth  mem_rsp_rdata_i, shared by all requesters
- flush_i  in  1  request quiesce
- flush_idle_o  out  1  no buffered or outstanding requests while quiesced
- err_o  out  1  sticky protocol error

Behaviour:
- Reset:
  - mem_req_valid_o=0, output buffer empty, rr pointer=0.
  - All outstanding counters=0, FSM=RUN, flush_idle_o=0, err_o=0.
  - mem_req_* data fields are 0 until the first load.
  - Reset mid-transaction discards the buffered request and all counters; late responses after reset set err_o.
- Eligibility: requester i is eligible when req_valid_i[i] && cnt[i] < MaxOutstanding && FSM==RUN.
- Accept condition: buffer empty OR (mem_req_valid_o && mem_req_ready_i).
- Grant:
  - When the accept condition holds, the first eligible index at or after rr (wrapping mod NrReq) gets req_ready_o=1.
  - req_ready_o is one-hot or zero and is combinational from the inputs and state.
- On grant:
  - The buffer loads the winner's fields, with tid={idx, req_tid}; mem_req_valid_o=1 next cycle (latency 1).
  - rr <= winner+1, wrapping from NrReq-1 to 0.
  - cnt[winner] increments.
- Hold: while mem_req_valid_o && !mem_req_ready_i, all mem_req_* outputs are held stable.
- Pipelining: a buffer consume and a new grant in the same cycle are allowed, giving full throughput of 1 request/cycle.
- Response routing:
  - rsp_valid_o[mem_rsp_tid_i[top IdxW bits]] = mem_rsp_valid_i, combinational, 0 latency.
  - That requester's cnt decrements.
  - Grant increment and response decrement on the same requester in the same cycle leave cnt unchanged.
- Errors:
  - A response to a requester with cnt==0 sets err_o; the counter does not underflow.
  - A response whose index is >=NrReq sets err_o, and no rsp_valid_o bit is asserted.
  - err_o is cleared only by reset.
- FSM:
  - RUN -> DRAIN when flush_i=1; no new grants from that cycle.
  - DRAIN -> IDLE when the buffer is empty and all cnt==0. Checked in the same cycle, so an already-empty system reaches IDLE 1 cycle after flush_i.
  - IDLE: flush_idle_o=1, registered.
  - IDLE -> RUN when flush_i=0; flush_idle_o=0 in that same transition.
  - flush_i dropping during DRAIN -> back to RUN.
- Counter width: $clog2(MaxOutstanding+1).

Decomposition:
- A shared package (hpdcache_arb_pkg) holds:
  - the request struct {addr, we, wdata, be, tid};
  - the arbiter FSM enum {RUN, DRAIN, IDLE};
  - the tag-packing helper functions.
- NrReq and the data widths come from the cva6 configuration record (DcacheIdWidth feeds TidWidth).
- One natural sub-module: rr_arbiter_core, the combinational round-robin pick with pointer register.

Test Plan:
- Single requester 1 issues 3 back-to-back loads with mem_req_ready_i=1 -> mem_req_valid_o on cycles 1,2,3 with tids {1,t}, cnt[1] goes to 3; three responses return rsp_valid_o=3'b010 each cycle and cnt[1]=0.
- All 3 requesters valid continuously -> grants ordered 0,1,2,0,1,2 with one grant per cycle.
- mem_req_ready_i=0 for 4 cycles with a buffered store addr=0x8000_0000 -> outputs stable for all 4 cycles and req_ready_o=0 throughout.
- Requester 0 reaches MaxOutstanding=4 -> req_ready_o[0]=0 while requesters 1 and 2 are still granted; one response to requester 0 -> requester 0 is granted again.
- flush_i with 2 outstanding -> no grants; flush_idle_o rises 1 cycle after the last response; flush_i=0 -> grants resume.
- Response with tid index 0 while cnt[0]=0 -> err_o=1, stays set until rst_i.
